// File: rtl/button_step_conditioner.sv
// Push-button front end: two-flop synchroniser, counting debouncer, registered
// press/release edge pulses and a hold-to-auto-repeat step strobe.
module button_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RPT  = 2'd2;

  logic          sync1;
  logic          sync_q;
  logic [DW-1:0] db_cnt;
  logic          db_diff;
  logic          db_flip;
  logic          rise;
  logic          fall;
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_n;
  logic          rep_fire;

  // Stage 0: bring the asynchronous button into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync1  <= btn_in;
      sync_q <= sync1;
    end
  end

  assign db_diff = (sync_q != btn_level);
  assign db_flip = db_diff && (db_cnt == DB_LAST);
  assign rise    = db_flip && !btn_level;
  assign fall    = db_flip && btn_level;

  // Stage 1: any agreement with the current level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (!db_diff) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // Repeat scheduler; a release always wins over a coinciding terminal count
  always_comb begin
    state_n  = state;
    rcnt_n   = rcnt;
    rep_fire = 1'b0;
    case (state)
      IDLE: begin
        if (rise && (REPEAT_EN != 0)) begin
          state_n = HOLD;
          rcnt_n  = '0;
        end
      end
      HOLD: begin
        if (fall) begin
          state_n = IDLE;
          rcnt_n  = '0;
        end else if (rcnt == DELAY_LAST) begin
          rep_fire = 1'b1;
          state_n  = RPT;
          rcnt_n   = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      RPT: begin
        if (fall) begin
          state_n = IDLE;
          rcnt_n  = '0;
        end else if (rcnt == PER_LAST) begin
          rep_fire = 1'b1;
          rcnt_n   = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        rcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
    end
  end

  // Stage 2: registered one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      step_pulse    <= rise | rep_fire;
    end
  end

endmodule

// File: tb/tb_button_step_conditioner.sv
// Bench for button_step_conditioner: per-cycle expected vectors built from the
// timing rules, driven through a scoreboard queue, plus reset and no-repeat cases.
module tb_button_step_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  typedef struct {
    logic       btn;
    logic [3:0] exp;
    string      tag;
    int         edge_no;
  } vec_t;

  typedef struct {
    string tag;
    int    pre;
    int    hold;
    int    low;
  } scen_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn2 = 1'b0;
  logic lvl, pr, rl, st;
  logic lvl2, pr2, rl2, st2;

  int errors = 0;
  int checks = 0;

  vec_t  vecs[$];
  vec_t  exp_q[$];
  vec_t  mv;
  scen_t scen[7];

  always #5 clk = ~clk;

  button_step_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl),
    .press_pulse(pr), .release_pulse(rl), .step_pulse(st)
  );

  button_step_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_norep (
    .clk(clk), .rst(rst), .btn_in(btn2), .btn_level(lvl2),
    .press_pulse(pr2), .release_pulse(rl2), .step_pulse(st2)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Expected outputs {level, press, release, step} per edge, from the
  // debounce latency (DEB+2) and the repeat schedule (RD, then every RP).
  function automatic void gen(string tag, int pre, int hold, int low, int max_edges);
    logic [4:0] bpat;
    int n, rise, fall;
    bit active;
    vec_t v;
    bpat   = 5'b01101;
    n      = pre + hold + low;
    if (max_edges > 0 && max_edges < n) n = max_edges;
    active = (hold >= DEB);
    rise   = pre + DEB + 2;
    fall   = pre + hold + DEB + 2;
    for (int e = 1; e <= n; e++) begin
      if (e <= pre)             v.btn = bpat[e-1];
      else if (e <= pre + hold) v.btn = 1'b1;
      else                      v.btn = 1'b0;
      v.exp[3] = active && (e >= rise) && (e < fall);
      v.exp[2] = active && (e == rise);
      v.exp[1] = active && (e == fall);
      v.exp[0] = active && ((e == rise) ||
                 ((e >= rise + RD) && (e < fall) && (((e - rise - RD) % RP) == 0)));
      v.tag     = tag;
      v.edge_no = e;
      vecs.push_back(v);
    end
  endfunction

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      btn_in = vecs[i].btn;
      exp_q.push_back(vecs[i]);
    end
    @(posedge clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    vecs.delete();
  endtask

  // Monitor: pops one expectation per edge and compares after the edge settles
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mv = exp_q.pop_front();
      check($sformatf("%s@e%0d", mv.tag, mv.edge_no), {28'd0, lvl, pr, rl, st}, {28'd0, mv.exp});
      check($sformatf("norep_idle_%s@e%0d", mv.tag, mv.edge_no), {28'd0, lvl2, pr2, rl2, st2}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npr, nst, nrl, first_st;

    scen[0] = '{"clean", 0, 40, 10};
    scen[1] = '{"bounce", 5, 14, 10};
    scen[2] = '{"short", 0, 8, 10};
    scen[3] = '{"rel_on_period", 0, 20, 10};
    scen[4] = '{"rel_on_delay", 0, 10, 10};
    scen[5] = '{"glitch3", 0, 3, 10};
    scen[6] = '{"min_hold4", 0, 4, 10};

    // Reset with the button pressed: nothing may leak through
    rst = 1'b1;
    btn_in = 1'b1;
    btn2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, lvl, pr, rl, st}, 32'd0);
    check("reset_outputs_norep", {28'd0, lvl2, pr2, rl2, st2}, 32'd0);
    btn_in = 1'b0;
    btn2 = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;

    for (int s = 0; s < 7; s++) begin
      gen(scen[s].tag, scen[s].pre, scen[s].hold, scen[s].low, 0);
      run_vecs();
    end

    // Hold into the repeat phase, stop right after the edge-21 step pulse
    gen("pre_rst", 0, 100, 0, 21);
    run_vecs();
    check("step_before_rst", {31'd0, st}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {28'd0, lvl, pr, rl, st}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_outputs", {28'd0, lvl, pr, rl, st}, 32'd0);
    #2;
    rst = 1'b0;
    gen("post_rst", 0, 28, 10, 0);
    run_vecs();

    // Repeat disabled: a long hold gives exactly one press and one step
    npr = 0;
    nst = 0;
    nrl = 0;
    first_st = -1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk);
      btn2 = 1'b1;
      @(posedge clk);
      #1;
      if (pr2) npr++;
      if (st2) begin
        nst++;
        if (first_st < 0) first_st = e;
      end
    end
    check("norep_level_held", {31'd0, lvl2}, 32'd1);
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      btn2 = 1'b0;
      @(posedge clk);
      #1;
      if (rl2) nrl++;
      if (st2) nst++;
      if (pr2) npr++;
    end
    check("norep_press_count", npr, 1);
    check("norep_step_count", nst, 1);
    check("norep_first_step_edge", first_st, DEB + 2);
    check("norep_release_count", nrl, 1);
    check("norep_level_final", {31'd0, lvl2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
